// File: rtl/logic_unit_arbiter.sv
// Four-requester round-robin arbiter sharing one bitwise logic unit.
// Accept in IDLE, compute in EXEC, hold the result in RESP until taken.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [11:0]          req_op,
  input  logic [4*WIDTH-1:0]   req_a,
  input  logic [4*WIDTH-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 busy,
  output logic [7:0]           done_cnt
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned OP_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:0]       last_grant_q;
  logic [1:0]       owner_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] rsp_data_d;
  logic [1:0]       rsp_id_q;
  logic [7:0]       done_cnt_q;
  logic [7:0]       done_cnt_d;

  logic             grant_any;
  logic [1:0]       grant_idx;

  function automatic logic [WIDTH-1:0] logic_op(input logic [OP_W-1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~(a & b);
      3'b011:  return ~(a | b);
      3'b100:  return a ^ b;
      3'b101:  return ~(a ^ b);
      3'b110:  return ~a;
      default: return ~b;
    endcase
  endfunction

  // Walk candidates farthest-first so the nearest one after last_grant wins.
  always_comb begin : grant_sel
    logic [1:0] cand;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = 2'(last_grant_q + 2'(k) + 2'd1);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign req_ready  = (state_q == IDLE && !rst && grant_any) ? (4'b0001 << grant_idx) : 4'b0000;
  assign rsp_data_d = logic_op(op_q, a_q, b_q);
  assign done_cnt_d = done_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      owner_q      <= 2'd0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 2'd0;
      done_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            op_q         <= req_op[OP_W*int'(grant_idx) +: OP_W];
            a_q          <= req_a[WIDTH*int'(grant_idx) +: WIDTH];
            b_q          <= req_b[WIDTH*int'(grant_idx) +: WIDTH];
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q <= rsp_data_d;
          rsp_id_q   <= owner_q;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            done_cnt_q <= done_cnt_d;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_cnt_q;

endmodule
